// File: rtl/arf_pkg.sv
// Shared encodings for the AddressRegisterFile control fields and the sequencer state machine.
package arf_pkg;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_STK   = 1;
  localparam int unsigned REQ_LD    = 2;

  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [1:0] FUN_CLR  = 2'b11;

  localparam logic [2:0] RS_NONE = 3'b000;
  localparam logic [2:0] RS_PC   = 3'b100;
  localparam logic [2:0] RS_AR   = 3'b010;
  localparam logic [2:0] RS_SP   = 3'b001;

  localparam logic [1:0] SEL_PC = 2'b00;
  localparam logic [1:0] SEL_SP = 2'b10;
  localparam logic [1:0] SEL_AR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_F_ADDR  = 3'd1,
    ST_F_INC   = 3'd2,
    ST_PU_DEC  = 3'd3,
    ST_PU_ADDR = 3'd4,
    ST_PO_ADDR = 3'd5,
    ST_PO_INC  = 3'd6,
    ST_LOAD    = 3'd7
  } state_t;

  // Maps the OutSel-style load target onto the one-hot RegSel enable.
  function automatic logic [2:0] ld_reg_sel(input logic [1:0] sel);
    case (sel)
      SEL_SP:  ld_reg_sel = RS_SP;
      SEL_AR:  ld_reg_sel = RS_AR;
      default: ld_reg_sel = RS_PC;
    endcase
  endfunction

endpackage

// File: rtl/arf_rr_arbiter.sv
// Three-way arbiter: round-robin from a rotating pointer, or fixed priority fetch > stack > load.
module arf_rr_arbiter
  import arf_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic                 i_update,
  output logic [NUM_REQ-1:0]   o_gnt_c
);

  logic [1:0]         r_ptr;
  logic [1:0]         w_ptr_nxt;
  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_pick;

  // Lowest set bit wins after rotating the request vector so the pointer sits at bit 0.
  always_comb begin
    w_rot     = i_req;
    w_pick    = '0;
    o_gnt_c   = '0;
    w_ptr_nxt = r_ptr;
    if (RR_EN) begin
      case (r_ptr)
        2'd1:    w_rot = {i_req[0], i_req[2], i_req[1]};
        2'd2:    w_rot = {i_req[1], i_req[0], i_req[2]};
        default: w_rot = i_req;
      endcase
      w_pick = w_rot & 3'(~w_rot + 3'd1);
      case (r_ptr)
        2'd1:    o_gnt_c = {w_pick[1], w_pick[0], w_pick[2]};
        2'd2:    o_gnt_c = {w_pick[0], w_pick[2], w_pick[1]};
        default: o_gnt_c = w_pick;
      endcase
      if (o_gnt_c[REQ_FETCH])    w_ptr_nxt = 2'd1;
      else if (o_gnt_c[REQ_STK]) w_ptr_nxt = 2'd2;
      else if (o_gnt_c[REQ_LD])  w_ptr_nxt = 2'd0;
    end else begin
      w_pick  = i_req & 3'(~i_req + 3'd1);
      o_gnt_c = w_pick;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 2'd0;
    end else if (i_update) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/arf_access_sequencer.sv
// Grants the AddressRegisterFile to fetch, stack or load requesters and plays out each
// short micro-sequence on the ARF control lines, flagging cycles that carry a memory address.
module arf_access_sequencer
  import arf_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter bit          RR_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_fetch_req,
  output logic             o_fetch_ack,
  input  logic             i_stk_req,
  input  logic             i_stk_pop,
  output logic             o_stk_ack,
  input  logic             i_ld_req,
  input  logic [1:0]       i_ld_sel,
  input  logic [WIDTH-1:0] i_ld_data,
  output logic             o_ld_ack,
  output logic [WIDTH-1:0] o_i,
  output logic [2:0]       o_reg_sel,
  output logic [1:0]       o_fun_sel,
  output logic [1:0]       o_out_c_sel,
  output logic [1:0]       o_out_d_sel,
  output logic             o_addr_valid,
  output logic             o_busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_req;

  logic [WIDTH-1:0]   w_i;
  logic [2:0]         w_reg_sel;
  logic [1:0]         w_fun_sel;
  logic [1:0]         w_out_d_sel;
  logic               w_addr_valid;
  logic               w_fetch_ack;
  logic               w_stk_ack;
  logic               w_ld_ack;

  assign w_req = {i_ld_req, i_stk_req, i_fetch_req};

  arf_rr_arbiter #(
    .RR_EN (RR_EN)
  ) u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (w_req),
    .i_update (r_state == ST_IDLE),
    .o_gnt_c  (w_gnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, then the control word for that state so every output leaves a flop.
  always_comb begin
    w_state_nxt  = r_state;
    w_i          = '0;
    w_reg_sel    = RS_NONE;
    w_fun_sel    = FUN_DEC;
    w_out_d_sel  = SEL_PC;
    w_addr_valid = 1'b0;
    w_fetch_ack  = 1'b0;
    w_stk_ack    = 1'b0;
    w_ld_ack     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_gnt[REQ_FETCH])    w_state_nxt = ST_F_ADDR;
        else if (w_gnt[REQ_STK]) w_state_nxt = i_stk_pop ? ST_PO_ADDR : ST_PU_DEC;
        else if (w_gnt[REQ_LD])  w_state_nxt = ST_LOAD;
      end
      ST_F_ADDR:  w_state_nxt = ST_F_INC;
      ST_PU_DEC:  w_state_nxt = ST_PU_ADDR;
      ST_PO_ADDR: w_state_nxt = ST_PO_INC;
      default:    w_state_nxt = ST_IDLE;
    endcase

    // LOAD is only ever entered from IDLE, so the live LdSel/LdData are the grant-time values.
    case (w_state_nxt)
      ST_F_ADDR: begin
        w_out_d_sel  = SEL_PC;
        w_addr_valid = 1'b1;
      end
      ST_F_INC: begin
        w_reg_sel   = RS_PC;
        w_fun_sel   = FUN_INC;
        w_fetch_ack = 1'b1;
      end
      ST_PU_DEC: begin
        w_reg_sel = RS_SP;
        w_fun_sel = FUN_DEC;
      end
      ST_PU_ADDR: begin
        w_out_d_sel  = SEL_SP;
        w_addr_valid = 1'b1;
        w_stk_ack    = 1'b1;
      end
      ST_PO_ADDR: begin
        w_out_d_sel  = SEL_SP;
        w_addr_valid = 1'b1;
      end
      ST_PO_INC: begin
        w_reg_sel = RS_SP;
        w_fun_sel = FUN_INC;
        w_stk_ack = 1'b1;
      end
      ST_LOAD: begin
        w_reg_sel = ld_reg_sel(i_ld_sel);
        w_fun_sel = FUN_LOAD;
        w_i       = i_ld_data;
        w_ld_ack  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_i          <= '0;
      o_reg_sel    <= RS_NONE;
      o_fun_sel    <= FUN_DEC;
      o_out_d_sel  <= SEL_PC;
      o_addr_valid <= 1'b0;
      o_fetch_ack  <= 1'b0;
      o_stk_ack    <= 1'b0;
      o_ld_ack     <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_i          <= w_i;
      o_reg_sel    <= w_reg_sel;
      o_fun_sel    <= w_fun_sel;
      o_out_d_sel  <= w_out_d_sel;
      o_addr_valid <= w_addr_valid;
      o_fetch_ack  <= w_fetch_ack;
      o_stk_ack    <= w_stk_ack;
      o_ld_ack     <= w_ld_ack;
      o_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_out_c_sel = SEL_PC;

endmodule

// File: tb/tb_arf_access_sequencer.sv
// Bench: drives the sequencer against a behavioural ARF (PC/SP/AR) and scores every busy cycle.
module tb_arf_access_sequencer;

  localparam int unsigned W = 16;

  typedef struct {
    logic [2:0]   rs;
    logic [1:0]   fs;
    logic [1:0]   ds;
    logic         av;
    logic [2:0]   ack;
    logic [W-1:0] od;
    logic [W-1:0] i;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         fetch_req = 1'b0, stk_req = 1'b0, stk_pop = 1'b0, ld_req = 1'b0;
  logic [1:0]   ld_sel = 2'b00;
  logic [W-1:0] ld_data = '0;
  logic         fetch_ack, stk_ack, ld_ack, addr_valid, busy;
  logic [W-1:0] arf_i;
  logic [2:0]   reg_sel;
  logic [1:0]   fun_sel, out_c_sel, out_d_sel;

  logic         fp_req = 1'b0;
  logic         fp_fetch_ack, fp_stk_ack, fp_ld_ack, fp_addr_valid, fp_busy;
  logic [W-1:0] fp_i;
  logic [2:0]   fp_reg_sel;
  logic [1:0]   fp_fun_sel, fp_out_c_sel, fp_out_d_sel;

  logic [W-1:0] m_pc = '0, m_sp = '0, m_ar = '0, m_outd;
  logic         pre_en = 1'b0;
  logic [W-1:0] pre_pc = '0, pre_sp = '0, pre_ar = '0;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  arf_access_sequencer #(.WIDTH(W), .RR_EN(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetch_req(fetch_req), .o_fetch_ack(fetch_ack),
    .i_stk_req(stk_req), .i_stk_pop(stk_pop), .o_stk_ack(stk_ack),
    .i_ld_req(ld_req), .i_ld_sel(ld_sel), .i_ld_data(ld_data), .o_ld_ack(ld_ack),
    .o_i(arf_i), .o_reg_sel(reg_sel), .o_fun_sel(fun_sel),
    .o_out_c_sel(out_c_sel), .o_out_d_sel(out_d_sel),
    .o_addr_valid(addr_valid), .o_busy(busy)
  );

  arf_access_sequencer #(.WIDTH(W), .RR_EN(1'b0)) dut_fp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetch_req(fp_req), .o_fetch_ack(fp_fetch_ack),
    .i_stk_req(fp_req), .i_stk_pop(1'b0), .o_stk_ack(fp_stk_ack),
    .i_ld_req(fp_req), .i_ld_sel(2'b11), .i_ld_data(16'hA5A5), .o_ld_ack(fp_ld_ack),
    .o_i(fp_i), .o_reg_sel(fp_reg_sel), .o_fun_sel(fp_fun_sel),
    .o_out_c_sel(fp_out_c_sel), .o_out_d_sel(fp_out_d_sel),
    .o_addr_valid(fp_addr_valid), .o_busy(fp_busy)
  );

  function automatic logic [W-1:0] arf_fn(input logic [W-1:0] x, input logic [1:0] fs,
                                          input logic [W-1:0] d);
    case (fs)
      2'b00:   arf_fn = W'(x - 1'b1);
      2'b01:   arf_fn = W'(x + 1'b1);
      2'b10:   arf_fn = d;
      default: arf_fn = '0;
    endcase
  endfunction

  // Behavioural AddressRegisterFile driven by the DUT control word.
  always @(posedge clk) begin
    if (pre_en) begin
      m_pc <= pre_pc; m_sp <= pre_sp; m_ar <= pre_ar;
    end else begin
      if (reg_sel[2]) m_pc <= arf_fn(m_pc, fun_sel, arf_i);
      if (reg_sel[1]) m_ar <= arf_fn(m_ar, fun_sel, arf_i);
      if (reg_sel[0]) m_sp <= arf_fn(m_sp, fun_sel, arf_i);
    end
  end

  always_comb begin
    case (out_d_sel)
      2'b10:   m_outd = m_sp;
      2'b11:   m_outd = m_ar;
      default: m_outd = m_pc;
    endcase
  end

  // Advance to the next falling edge and score the cycle against the expectation queue.
  task automatic tick();
    logic active;
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      active = (reg_sel != 3'b000) || addr_valid || fetch_ack || stk_ack || ld_ack;
      if (active || busy) begin
        total++;
        if (busy !== active) begin
          bad++;
          $display("FAIL busy_flag: busy=%b active=%b", busy, active);
        end
      end
      if (active) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_cycle: rs=%b av=%b ack=%b with nothing expected",
                   reg_sel, addr_valid, {fetch_ack, stk_ack, ld_ack});
        end else begin
          e = q.pop_front();
          if (reg_sel !== e.rs || out_d_sel !== e.ds || addr_valid !== e.av ||
              {fetch_ack, stk_ack, ld_ack} !== e.ack || out_c_sel !== 2'b00 ||
              (e.rs != 3'b000 && fun_sel !== e.fs) || (e.av && m_outd !== e.od) ||
              (e.ack[0] && arf_i !== e.i)) begin
            bad++;
            $display("FAIL sb_cycle: got rs=%b fs=%b ds=%b cs=%b av=%b ack=%b od=%h i=%h want rs=%b fs=%b ds=%b av=%b ack=%b od=%h i=%h",
                     reg_sel, fun_sel, out_d_sel, out_c_sel, addr_valid,
                     {fetch_ack, stk_ack, ld_ack}, m_outd, arf_i,
                     e.rs, e.fs, e.ds, e.av, e.ack, e.od, e.i);
          end
        end
      end
    end
  endtask

  task automatic exp_fetch(input logic [W-1:0] pc);
    q.push_back('{rs:3'b000, fs:2'b00, ds:2'b00, av:1'b1, ack:3'b000, od:pc, i:'0});
    q.push_back('{rs:3'b100, fs:2'b01, ds:2'b00, av:1'b0, ack:3'b100, od:'0, i:'0});
  endtask

  task automatic exp_push(input logic [W-1:0] sp);
    q.push_back('{rs:3'b001, fs:2'b00, ds:2'b00, av:1'b0, ack:3'b000, od:'0, i:'0});
    q.push_back('{rs:3'b000, fs:2'b00, ds:2'b10, av:1'b1, ack:3'b010, od:W'(sp - 1'b1), i:'0});
  endtask

  task automatic exp_pop(input logic [W-1:0] sp);
    q.push_back('{rs:3'b000, fs:2'b00, ds:2'b10, av:1'b1, ack:3'b000, od:sp, i:'0});
    q.push_back('{rs:3'b001, fs:2'b01, ds:2'b00, av:1'b0, ack:3'b010, od:'0, i:'0});
  endtask

  task automatic exp_load(input logic [1:0] sel, input logic [W-1:0] data);
    logic [2:0] rs;
    rs = (sel == 2'b10) ? 3'b001 : (sel == 2'b11) ? 3'b010 : 3'b100;
    q.push_back('{rs:rs, fs:2'b10, ds:2'b00, av:1'b0, ack:3'b001, od:'0, i:data});
  endtask

  task automatic preset(input logic [W-1:0] pc, input logic [W-1:0] sp, input logic [W-1:0] ar);
    pre_pc = pc; pre_sp = sp; pre_ar = ar; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  // Raises one request, waits (bounded) for its Ack, drops it; lat counts edges from the
  // sampling edge to the edge that sees Ack, or -1 on timeout. Ends back in IDLE.
  task automatic run_req(input int kind, input bit flip, output int lat);
    logic a;
    lat = -1;
    case (kind)
      0:       fetch_req = 1'b1;
      1:       stk_req = 1'b1;
      default: ld_req = 1'b1;
    endcase
    for (int n = 0; n < 8; n++) begin
      tick();
      if (n == 0 && flip) begin
        stk_pop = ~stk_pop;
        ld_data = ~ld_data;
      end
      a = (kind == 0) ? fetch_ack : (kind == 1) ? stk_ack : ld_ack;
      if (a) begin
        lat = n + 2;
        break;
      end
    end
    fetch_req = 1'b0; stk_req = 1'b0; ld_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    total++;
    if ({reg_sel, fun_sel, out_c_sel, out_d_sel, addr_valid, fetch_ack, stk_ack, ld_ack, busy, arf_i} !== '0) begin
      bad++;
      $display("FAIL reset_hold: rs=%b fs=%b ds=%b av=%b busy=%b i=%h want all zero",
               reg_sel, fun_sel, out_d_sel, addr_valid, busy, arf_i);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({reg_sel, addr_valid, fetch_ack, stk_ack, ld_ack, busy} !== '0) begin
      bad++;
      $display("FAIL reset_idle: rs=%b av=%b busy=%b want 0", reg_sel, addr_valid, busy);
    end
  endtask

  task automatic test_fetch();
    int lat;
    preset(16'h1234, 16'h3456, 16'h0000);
    exp_fetch(16'h1234);
    run_req(0, 1'b0, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL fetch_latency: got %0d want 3", lat); end
    total++;
    if (m_pc !== 16'h1235) begin bad++; $display("FAIL fetch_pc: got %h want 1235", m_pc); end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL fetch_drain: %0d left want 0", q.size()); end
  endtask

  task automatic test_push_pop();
    int lat;
    stk_pop = 1'b0;
    exp_push(16'h3456);
    run_req(1, 1'b1, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL push_latency: got %0d want 3", lat); end
    total++;
    if (m_sp !== 16'h3455) begin bad++; $display("FAIL push_sp: got %h want 3455", m_sp); end
    stk_pop = 1'b1;
    exp_pop(16'h3455);
    run_req(1, 1'b0, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL pop_latency: got %0d want 3", lat); end
    total++;
    if (m_sp !== 16'h3456) begin bad++; $display("FAIL pop_sp: got %h want 3456", m_sp); end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL stack_drain: %0d left want 0", q.size()); end
  endtask

  task automatic test_load();
    int lat;
    ld_sel = 2'b11; ld_data = 16'h5678;
    exp_load(2'b11, 16'h5678);
    run_req(2, 1'b0, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL load_latency: got %0d want 2", lat); end
    total++;
    if ({m_ar, m_pc, m_sp} !== {16'h5678, 16'h1235, 16'h3456}) begin
      bad++;
      $display("FAIL load_regs: got ar=%h pc=%h sp=%h want 5678 1235 3456", m_ar, m_pc, m_sp);
    end
  endtask

  task automatic test_round_robin();
    int order[4];
    int at[4];
    int k;
    int n;
    k = 0;
    n = 0;
    stk_pop = 1'b1; ld_sel = 2'b10; ld_data = 16'h2000;
    exp_fetch(16'h1235);
    exp_pop(16'h3456);
    exp_load(2'b10, 16'h2000);
    exp_fetch(16'h1236);
    fetch_req = 1'b1; stk_req = 1'b1; ld_req = 1'b1;
    while (k < 4 && n < 40) begin
      tick();
      if (fetch_ack || stk_ack || ld_ack) begin
        order[k] = fetch_ack ? 0 : stk_ack ? 1 : 2;
        at[k] = n;
        k++;
      end
      n++;
    end
    fetch_req = 1'b0; stk_req = 1'b0; ld_req = 1'b0;
    tick();
    total++;
    if (k != 4) begin
      bad++;
      $display("FAIL rr_timeout: got %0d acks want 4", k);
    end else begin
      total++;
      if (order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 0) begin
        bad++;
        $display("FAIL rr_order: got %0d %0d %0d %0d want 0 1 2 0",
                 order[0], order[1], order[2], order[3]);
      end
      total++;
      if (at[1] - at[0] != 3 || at[2] - at[1] != 2 || at[3] - at[2] != 3) begin
        bad++;
        $display("FAIL rr_gaps: got %0d %0d %0d want 3 2 3",
                 at[1] - at[0], at[2] - at[1], at[3] - at[2]);
      end
    end
    total++;
    if ({m_pc, m_sp} !== {16'h1237, 16'h2000}) begin
      bad++;
      $display("FAIL rr_regs: got pc=%h sp=%h want 1237 2000", m_pc, m_sp);
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL rr_drain: %0d left want 0", q.size()); end
  endtask

  task automatic test_fixed_priority();
    int nf;
    int no;
    nf = 0;
    no = 0;
    fp_req = 1'b1;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (fp_fetch_ack) nf++;
      if (fp_stk_ack || fp_ld_ack) no++;
    end
    fp_req = 1'b0;
    tick();
    tick();
    total++;
    if (nf != 10 || no != 0) begin
      bad++;
      $display("FAIL fixed_priority: got fetch=%0d other=%0d want 10 0", nf, no);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    preset(16'h1234, 16'h3456, 16'h5678);
    q.push_back('{rs:3'b000, fs:2'b00, ds:2'b00, av:1'b1, ack:3'b000, od:16'h1234, i:'0});
    fetch_req = 1'b1;
    tick();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({reg_sel, fun_sel, out_d_sel, addr_valid, fetch_ack, stk_ack, ld_ack, busy} !== '0) begin
      bad++;
      $display("FAIL reset_abort: rs=%b fs=%b ds=%b av=%b ack=%b busy=%b want all zero",
               reg_sel, fun_sel, out_d_sel, addr_valid, {fetch_ack, stk_ack, ld_ack}, busy);
    end
    tick();
    total++;
    if (m_pc !== 16'h1234 || fetch_ack !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_write: got pc=%h ack=%b want 1234 0", m_pc, fetch_ack);
    end
    exp_fetch(16'h1234);
    rst_n = 1'b1;
    run_req(0, 1'b0, lat);
    total++;
    if (lat !== 3 || m_pc !== 16'h1235) begin
      bad++;
      $display("FAIL reset_restart: got lat=%0d pc=%h want 3 1235", lat, m_pc);
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL reset_drain: %0d left want 0", q.size()); end
  endtask

  task automatic test_wrap();
    int lat;
    preset(16'hFFFF, 16'h0000, 16'h0000);
    stk_pop = 1'b0;
    exp_push(16'h0000);
    run_req(1, 1'b0, lat);
    total++;
    if (m_sp !== 16'hFFFF) begin bad++; $display("FAIL wrap_sp: got %h want ffff", m_sp); end
    exp_fetch(16'hFFFF);
    run_req(0, 1'b0, lat);
    total++;
    if (m_pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc: got %h want 0000", m_pc); end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL wrap_drain: %0d left want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_push_pop();
    test_load();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
